// File: rtl/led_mode_sequencer.sv
// led_mode_sequencer
//
// Drives the board LEDs from the 2-bit LED-mode value of the LED-mode PIO.
// Modes: off, static pattern, blink, running light. Carries its own step
// prescaler and a 4-word Avalon-MM slave:
//   addr0 DIV     RW  step divider, step period = DIV+1 clk cycles
//   addr1 CTRL    RW  bit0 ENABLE, bit1 IRQ_EN
//   addr2 STATUS      bits[1:0] state code (RO), bit8 WRAP (write 1 to clear)
//   addr3 PATTERN RW  LED pattern for static and blink modes
//
// Ports:
//   clk, reset_n      system clock, asynchronous active-low reset
//   mode              LED mode from PIO (0 off, 1 static, 2 blink, 3 run)
//   address           Avalon word address
//   chipselect        Avalon select
//   write_n           Avalon write strobe, active-low
//   writedata         Avalon write data
//   readdata          Avalon read data, combinational, zero wait states
//   leds              registered LED drive
//   irq               registered wrap interrupt, level, active-high
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_OFF    | LEDs dark, prescaler held at 0
// ST_STATIC | LEDs follow PATTERN every cycle, prescaler held at 0
// ST_BLINK  | LEDs toggle between PATTERN and 0 on every prescaler tick
// ST_RUN    | single lit LED advances on every tick, wraps and flags WRAP

module led_mode_sequencer #(
   parameter int NUM_LEDS    = 8,
   parameter int DIV_WIDTH   = 24,
   parameter int DEFAULT_DIV = 12499999
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [1:0]           mode,
   input  logic [1:0]           address,
   input  logic                 chipselect,
   input  logic                 write_n,
   input  logic [31:0]          writedata,
   output logic [31:0]          readdata,
   output logic [NUM_LEDS-1:0]  leds,
   output logic                 irq
);

   localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

   localparam logic [1:0] ADDR_DIV     = 2'd0;
   localparam logic [1:0] ADDR_CTRL    = 2'd1;
   localparam logic [1:0] ADDR_STATUS  = 2'd2;
   localparam logic [1:0] ADDR_PATTERN = 2'd3;

   localparam logic [DIV_WIDTH-1:0] DIV_RESET = DIV_WIDTH'(DEFAULT_DIV);
   localparam logic [POS_W-1:0]     POS_LAST  = POS_W'(NUM_LEDS - 1);
   localparam logic [NUM_LEDS-1:0]  LED_BIT0  = NUM_LEDS'(1);

   typedef enum logic [1:0] {
      ST_OFF    = 2'd0,
      ST_STATIC = 2'd1,
      ST_BLINK  = 2'd2,
      ST_RUN    = 2'd3
   } state_t;

   state_t                 state;
   logic [DIV_WIDTH-1:0]   div_q;
   logic [DIV_WIDTH-1:0]   cnt;
   logic                   ctrl_enable;
   logic                   ctrl_irq_en;
   logic [NUM_LEDS-1:0]    pattern_q;
   logic                   wrap_q;
   logic                   phase;
   logic [POS_W-1:0]       pos;

   logic                   wr_en;
   logic                   wr_div;
   logic                   wr_ctrl;
   logic                   wr_status;
   logic                   wr_pattern;
   logic [1:0]             eff_mode;
   logic                   entry;
   logic                   running;
   logic                   tick;
   logic                   wrap_set;
   logic                   wrap_clr;
   logic [POS_W-1:0]       pos_next;
   logic                   unused_writedata;

   // Upper writedata bits are don't-care for every register.
   assign unused_writedata = ^writedata;

   // ------------------------------------------------------------------
   // Register decode
   // ------------------------------------------------------------------
   assign wr_en      = chipselect & ~write_n;
   assign wr_div     = wr_en && (address == ADDR_DIV);
   assign wr_ctrl    = wr_en && (address == ADDR_CTRL);
   assign wr_status  = wr_en && (address == ADDR_STATUS);
   assign wr_pattern = wr_en && (address == ADDR_PATTERN);

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DIV:     readdata[DIV_WIDTH-1:0] = div_q;
         ADDR_CTRL:    readdata[1:0]           = {ctrl_irq_en, ctrl_enable};
         ADDR_STATUS: begin
            readdata[1:0] = state;
            readdata[8]   = wrap_q;
         end
         ADDR_PATTERN: readdata[NUM_LEDS-1:0]  = pattern_q;
         default:      readdata                = '0;
      endcase
   end

   // ------------------------------------------------------------------
   // Mode entry and prescaler tick
   // ------------------------------------------------------------------
   assign eff_mode = ctrl_enable ? mode : 2'd0;
   assign entry    = (eff_mode != state);
   assign running  = (state == ST_BLINK) || (state == ST_RUN);

   // A DIV write restarts the period, so it swallows a tick that would
   // otherwise land on the same edge. Mode entry restarts everything.
   assign tick     = running && !entry && !wr_div && (cnt == div_q);
   assign pos_next = pos + POS_W'(1);
   assign wrap_set = tick && (state == ST_RUN) && (pos == POS_LAST);
   assign wrap_clr = wr_status && writedata[8];

   // ------------------------------------------------------------------
   // Configuration registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q       <= DIV_RESET;
         ctrl_enable <= 1'b0;
         ctrl_irq_en <= 1'b0;
         pattern_q   <= '1;
         wrap_q      <= 1'b0;
         irq         <= 1'b0;
      end else begin
         if (wr_div) begin
            div_q <= writedata[DIV_WIDTH-1:0];
         end
         if (wr_ctrl) begin
            ctrl_enable <= writedata[0];
            ctrl_irq_en <= writedata[1];
         end
         if (wr_pattern) begin
            pattern_q <= writedata[NUM_LEDS-1:0];
         end
         // A wrap on the same edge as a clear must not be lost.
         if (wrap_set) begin
            wrap_q <= 1'b1;
         end else if (wrap_clr) begin
            wrap_q <= 1'b0;
         end
         irq <= wrap_q & ctrl_irq_en;
      end
   end

   // ------------------------------------------------------------------
   // Sequencer FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_OFF;
         cnt   <= '0;
         phase <= 1'b0;
         pos   <= '0;
         leds  <= '0;
      end else if (entry) begin
         state <= state_t'(eff_mode);
         cnt   <= '0;
         phase <= 1'b1;
         pos   <= '0;
         case (state_t'(eff_mode))
            ST_OFF:    leds <= '0;
            ST_STATIC: leds <= pattern_q;
            ST_BLINK:  leds <= pattern_q;
            ST_RUN:    leds <= LED_BIT0;
            default:   leds <= '0;
         endcase
      end else begin
         if (!running || wr_div || tick) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + DIV_WIDTH'(1);
         end

         case (state)
            ST_OFF: begin
               leds <= '0;
            end
            ST_STATIC: begin
               leds <= pattern_q;
            end
            ST_BLINK: begin
               if (tick) begin
                  phase <= ~phase;
                  leds  <= phase ? '0 : pattern_q;
               end
            end
            ST_RUN: begin
               if (tick) begin
                  if (pos == POS_LAST) begin
                     pos  <= '0;
                     leds <= LED_BIT0;
                  end else begin
                     pos  <= pos_next;
                     leds <= LED_BIT0 << pos_next;
                  end
               end
            end
            default: begin
               leds <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Directed testbench for led_mode_sequencer with default parameters.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.

module tb_led_mode_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  mode;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  leds;
   logic        irq;

   int total = 0;
   int bad   = 0;

   led_mode_sequencer dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .mode       (mode),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .leds       (leds),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      #1;
      check(tag, readdata, exp);
      chipselect = 1'b0;
   endtask

   task automatic chk_leds(input string tag, input logic [7:0] exp);
      check(tag, {24'h0, leds}, {24'h0, exp});
   endtask

   task automatic chk_irq(input string tag, input logic exp);
      check(tag, {31'h0, irq}, {31'h0, exp});
   endtask

   initial begin
      logic [7:0] e;
      reset_n    = 1'b0;
      mode       = 2'd0;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;

      // Reset state
      #22 reset_n = 1'b1;
      @(posedge clk);
      #1;
      rd(2'd0, 32'h00BE_BC1F, "rst_div");
      rd(2'd1, 32'h0, "rst_ctrl");
      rd(2'd2, 32'h0, "rst_status");
      rd(2'd3, 32'h0000_00FF, "rst_pattern");
      chk_leds("rst_leds", 8'h00);
      chk_irq("rst_irq", 1'b0);

      // Running light, DIV=3: shift every 4 clk, wrap sets WRAP
      wr(2'd0, 32'd3);
      wr(2'd1, 32'd1);
      mode = 2'd3;
      step(1);
      chk_leds("run_entry", 8'h01);
      step(3);
      chk_leds("run_hold", 8'h01);
      step(1);
      chk_leds("run_first_step", 8'h02);
      for (int i = 2; i < 8; i++) begin
         step(4);
         e = 8'h01 << i;
         check($sformatf("run_step%0d", i), {24'h0, leds}, {24'h0, e});
      end
      step(3);
      chk_leds("run_pre_wrap", 8'h80);
      step(1);
      chk_leds("run_wrap", 8'h01);
      rd(2'd2, 32'h0000_0103, "wrap_status");
      chk_irq("irq_masked", 1'b0);
      wr(2'd1, 32'd3);
      chk_irq("irq_lat0", 1'b0);
      step(1);
      chk_irq("irq_on", 1'b1);
      wr(2'd2, 32'h100);
      chk_irq("irq_clr_lat0", 1'b1);
      step(1);
      chk_irq("irq_off", 1'b0);
      rd(2'd2, 32'h0000_0003, "wrap_cleared");

      // Blink, PATTERN=0xA5, DIV=1
      wr(2'd1, 32'd1);
      wr(2'd3, 32'hFFFF_FFA5);
      wr(2'd0, 32'd1);
      mode = 2'd2;
      step(1);
      chk_leds("blink_entry", 8'hA5);
      step(1);
      chk_leds("blink_hold_on", 8'hA5);
      step(1);
      chk_leds("blink_off", 8'h00);
      step(1);
      chk_leds("blink_hold_off", 8'h00);
      step(1);
      chk_leds("blink_on", 8'hA5);
      wr(2'd1, 32'd0);
      step(1);
      chk_leds("disable_leds", 8'h00);
      rd(2'd2, 32'h0, "disable_status");

      // Static, pattern update, then switch to run
      mode = 2'd1;
      wr(2'd1, 32'd1);
      step(1);
      chk_leds("static_entry", 8'hA5);
      wr(2'd3, 32'h3C);
      chk_leds("static_pat_lat0", 8'hA5);
      step(1);
      chk_leds("static_pat", 8'h3C);
      rd(2'd3, 32'h3C, "pattern_rb");
      mode = 2'd3;
      step(1);
      chk_leds("static_to_run", 8'h01);
      step(1);
      chk_leds("run_cnt_restart", 8'h01);
      step(1);
      chk_leds("run_first_tick", 8'h02);

      // DIV rewrite at cnt==DIV swallows the tick; W1C on wrap edge loses
      mode = 2'd1;
      step(1);
      wr(2'd0, 32'd2);
      wr(2'd2, 32'h100);
      rd(2'd2, 32'h0000_0001, "static_status");
      mode = 2'd3;
      step(1);
      chk_leds("div2_entry", 8'h01);
      step(2);
      wr(2'd0, 32'hFF00_0002);
      chk_leds("div_wr_no_tick", 8'h01);
      step(2);
      chk_leds("div_wr_hold", 8'h01);
      step(1);
      chk_leds("div_wr_next_tick", 8'h02);
      for (int i = 2; i < 8; i++) begin
         step(3);
         e = 8'h01 << i;
         check($sformatf("div2_step%0d", i), {24'h0, leds}, {24'h0, e});
      end
      step(2);
      wr(2'd2, 32'h100);
      chk_leds("w1c_wrap_leds", 8'h01);
      rd(2'd2, 32'h0000_0103, "w1c_wrap_wins");

      // Asynchronous reset mid-run
      wr(2'd1, 32'd3);
      step(1);
      chk_irq("pre_rst_irq", 1'b1);
      step(1);
      chk_leds("pre_rst_step", 8'h02);
      step(9);
      chk_leds("pre_rst_leds", 8'h10);
      #2 reset_n = 1'b0;
      #1;
      chk_leds("async_rst_leds", 8'h00);
      chk_irq("async_rst_irq", 1'b0);
      rd(2'd0, 32'h00BE_BC1F, "async_rst_div");
      step(1);
      #2 reset_n = 1'b1;
      step(3);
      chk_leds("post_rst_disabled", 8'h00);
      rd(2'd1, 32'h0, "post_rst_ctrl");
      rd(2'd2, 32'h0, "post_rst_status");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/led_mode_sequencer.md
Name: led_mode_sequencer

Overview:
- Drives the board LEDs from the 2-bit LED-mode value produced by the LED-mode PIO. Four modes: off, static pattern, blink, running light.
- Has its own prescaler, plus a 4-word Avalon-MM slave that holds the step divider, control bits, status and pattern.
- Placed in the Qsys core next to the PIO. `mode` connects to the PIO `out_port`; `leds` goes to top-level pins; `irq` goes to the Nios II.

Parameters:
- NUM_LEDS, 8, LED count; width of `leds` and PATTERN; legal range 2..32.
- DIV_WIDTH, 24, prescaler/divider width; legal range 1..32.
- DEFAULT_DIV, 12499999, reset value of DIV. Step period = DIV+1 clk cycles (4 Hz at 50 MHz).

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- mode  in  2  LED mode from PIO, synchronous to clk: 0 off, 1 static, 2 blink, 3 run
- address  in  2  Avalon word address
- chipselect  in  1  Avalon select
- write_n  in  1  Avalon write strobe, active-low
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, combinational, zero wait states
- leds  out  NUM_LEDS  LED drive, registered
- irq  out  1  wrap interrupt, level, active-high

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk. All state on posedge clk.
- Reset values: leds=0, irq=0, DIV=DEFAULT_DIV, CTRL=0, PATTERN=all ones, WRAP=0, state=OFF, cnt=0, phase=0, pos=0.
- Register map; write = chipselect & ~write_n; reads are side-effect free; unused read bits are 0.
  - addr0 DIV: RW, bits [DIV_WIDTH-1:0].
  - addr1 CTRL: RW. bit0 ENABLE, bit1 IRQ_EN.
  - addr2 STATUS: bits[1:0] current state code (RO); bit8 WRAP (write 1 to clear; write 0 has no effect).
  - addr3 PATTERN: RW, bits [NUM_LEDS-1:0].
- Effective mode: eff = ENABLE ? mode : 0. FSM states OFF(0), STATIC(1), BLINK(2), RUN(3); state code = eff.
- Mode entry: on any edge where eff != state, all of the following load at that same edge:
  - state <= eff, cnt <= 0, phase <= 1, pos <= 0.
  - leds <= entry value: OFF 0; STATIC PATTERN; BLINK PATTERN; RUN bit0 only.
  - Latency: one clk from a mode/ENABLE change to `leds`.
- Prescaler: runs only in BLINK and RUN; held at 0 in OFF and STATIC.
  - tick = (cnt==DIV); on tick cnt <= 0, else cnt <= cnt+1.
  - DIV=0 gives a tick every cycle.
  - A write to DIV forces cnt <= 0 at the same edge; no tick is issued at that edge.
- STATIC: leds <= PATTERN every cycle; a PATTERN write shows on `leds` one clk later.
- BLINK: on tick, phase toggles. leds = phase ? PATTERN : 0, updated at the tick edge. PATTERN writes are used from the next phase=1 update.
- RUN: leds = one-hot at pos.
  - On tick, pos <= pos+1.
  - When pos==NUM_LEDS-1 and tick: pos <= 0, leds <= bit0, and WRAP <= 1.
- WRAP: if set and a W1C write occur at the same edge, set wins.
- irq = WRAP & IRQ_EN, registered, valid one clk after WRAP or IRQ_EN changes. Clearing IRQ_EN masks irq but leaves WRAP set.
- Precedence at one edge: mode entry beats tick; a DIV write still updates DIV.
- Reset asserted mid-sequence: all state returns to reset values immediately (async); no pending tick survives.
- Out-of-range writedata bits are ignored.

Test Plan:
- Reset, then read all 4 addresses -> readdata 0x00BEBC1F, 0, 0, 0xFF; leds=0x00; irq=0.
- DIV=3, CTRL=1, mode=3 at cycle T -> leds=0x01 at T+1, 0x02 at T+5, then shifts every 4 clk. After 0x80, the next tick gives 0x01 and STATUS bit8=1. With CTRL=3, irq=1 one clk later. Write 0x100 to addr2 -> WRAP=0, irq=0.
- PATTERN=0xA5, DIV=1, mode=2 -> leds=0xA5 one clk after entry, then alternates 0x00/0xA5 every 2 clk. Set CTRL.ENABLE=0 -> leds=0x00 next clk and STATUS[1:0]=0.
- mode=1, write PATTERN=0x3C -> leds=0x3C next clk. Change mode 1->3 mid-stream -> leds=0x01 next clk and cnt restarts from 0.
- RUN with DIV=2: write DIV=2 again at cnt==2 -> no tick at that edge; next tick 3 clk later. Apply W1C to WRAP on the same edge a wrap occurs -> WRAP stays 1.
- Assert reset_n low asynchronously mid-RUN (leds=0x10) -> leds=0, irq=0 immediately. After release with mode=3 but ENABLE=0 -> leds stays 0x00.
